roberts_mdc_stream_sequencer: RTL and testbench
===============================================

# roberts_mdc_stream_sequencer

Job-level controller for the Roberts MDC streamer. It latches one job descriptor (three TCDM base addresses and a pixel count) and waits until the in_pel source, in_size source and out_pel sink all report ready. It then launches all three address generators in one cycle and tracks their done events. It signals job completion, or a stall timeout, to the HWPE control slave. It sits between the register-file/FSM layer and the streamer's ctrl/flags structs, driving the flat fields of those structs.

## Interface
- TS_WIDTH, 16: width of the pixel count and of the transfer-size fields.
- TIMEOUT, 4096: number of RUN cycles without progress that triggers a timeout; must be ≥ 2.
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- clear_i  in  1  soft clear; synchronous; same effect as reset except on job_cnt_o.
- start_i  in  1  job start request; sampled only in IDLE.
- pel_addr_i / size_addr_i / out_addr_i  in  32 each  TCDM byte base addresses.
- n_pel_i  in  TS_WIDTH  pixels per job.
- rdy_pel_i / rdy_size_i / rdy_out_i  in  1 each  streamer ready_start flags.
- done_pel_i / done_size_i / done_out_i  in  1 each  streamer done pulses.
- beat_i  in  1  out_pel stream handshake (valid & ready); progress indicator.
- req_start_pel_o / req_start_size_o / req_start_out_o  out  1 each  address-generator start pulses.
- base_pel_o / base_size_o / base_out_o  out  32 each  latched base addresses.
- ts_pel_o / ts_size_o / ts_out_o  out  TS_WIDTH each  transfer sizes.
- busy_o  out  1  job in progress.
- evt_done_o  out  1  one-cycle pulse at job completion.
- err_cfg_o  out  1  one-cycle pulse when start_i is rejected.
- err_to_o  out  1  sticky timeout error.
- job_cnt_o  out  16  count of completed jobs; wraps.

## Operation
- States: IDLE, ARM, LAUNCH, RUN, DONE, ERR.
- IDLE
  - start_i=1 with n_pel_i≠0: latch the descriptor, set ts_pel=ts_out=n_pel_i and ts_size=1, go to ARM.
  - start_i=1 with n_pel_i=0: pulse err_cfg_o for one cycle, stay in IDLE, latch nothing.
- ARM: wait until rdy_pel_i, rdy_size_i and rdy_out_i are all 1, then go to LAUNCH. There is no timeout in ARM.
- LAUNCH (one cycle): all three req_start_*_o are 1 together. Clear the done-sticky bits and the stall counter. Go to RUN.
- RUN
  - Each done_*_i pulse sets its sticky bit. Any combination may arrive in the same cycle.
  - The stall counter clears on beat_i or on any done pulse; otherwise it increments.
  - When all three sticky bits are set (counting pulses arriving this cycle), go to DONE.
  - Otherwise, when the counter reaches TIMEOUT-1 with no progress this cycle, go to ERR.
  - Completion has priority over timeout when both happen in the same cycle.
- DONE (one cycle): evt_done_o=1 and job_cnt_o increments (0xFFFF wraps to 0). Go to IDLE.
- ERR: err_to_o=1, busy_o=1. Stays here until clear_i or rst_i. start_i is ignored.
- Done pulses received in IDLE, ARM, DONE or ERR are ignored.
- clear_i
  - Forces IDLE and zeroes the sticky bits, the counter and err_to_o.
  - Keeps job_cnt_o and the latched base/ts values.
  - Takes priority over every transition in the same cycle.
- rst_i additionally zeroes job_cnt_o and all base/ts registers. rst_i has priority over clear_i.

## Timing
- Reset values
  - All outputs are 0.
  - State is IDLE.
  - job_cnt_o, base_*_o and ts_*_o are all 0.
- All outputs are registered, except err_cfg_o and busy_o, which are decoded from registered state.
- busy_o is 1 in ARM, LAUNCH, RUN and ERR.
- Best-case latency: start_i accepted at cycle t → ARM at t+1 → req_start pulses at t+2 (if all ready at t+1).
- After the last done pulse at cycle u: evt_done_o at u+1, busy_o=0 at u+2, and a new start_i is accepted at u+2.
- base_*_o and ts_*_o are stable from ARM through DONE; they change only on an accepted start_i.
- A start_i held high across DONE→IDLE launches a back-to-back job.

## Test plan
- n_pel_i=64, all ready, then done_size@+3, done_pel@+70, done_out@+75 → single req_start pulse on all three, ts_pel=ts_out=64, ts_size=1, evt_done_o one cycle after done_out, job_cnt_o=1.
- rdy_out_i held low for 10 cycles after start → stays in ARM, no req_start; launch occurs the cycle after rdy_out_i rises.
- n_pel_i=0 with start_i → err_cfg_o one-cycle pulse, busy_o stays 0, base registers unchanged.
- TIMEOUT=16, launch, no beat_i or done pulses → err_to_o=1 at 16 cycles after LAUNCH; start_i ignored; clear_i → IDLE, err_to_o=0, job_cnt_o preserved.
- All three done pulses arrive in the same cycle that the counter hits TIMEOUT-1 → evt_done_o, no err_to_o.
- clear_i mid-RUN with job_cnt_o=0xFFFF, then a full job → IDLE; next completion wraps job_cnt_o to 0; rst_i mid-ARM → all outputs 0 the next cycle.

Source files
------------

// File: rtl/roberts_mdc_stream_sequencer.sv
// Job-level sequencer for the Roberts MDC streamer: latches one job descriptor,
// waits for the three streams to report ready, launches all address generators
// together, then tracks their done events until completion or a stall timeout.
module roberts_mdc_stream_sequencer #(
  parameter int TS_WIDTH = 16,
  parameter int TIMEOUT  = 4096
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic                start_i,
  input  logic [31:0]         pel_addr_i,
  input  logic [31:0]         size_addr_i,
  input  logic [31:0]         out_addr_i,
  input  logic [TS_WIDTH-1:0] n_pel_i,
  input  logic                rdy_pel_i,
  input  logic                rdy_size_i,
  input  logic                rdy_out_i,
  input  logic                done_pel_i,
  input  logic                done_size_i,
  input  logic                done_out_i,
  input  logic                beat_i,
  output logic                req_start_pel_o,
  output logic                req_start_size_o,
  output logic                req_start_out_o,
  output logic [31:0]         base_pel_o,
  output logic [31:0]         base_size_o,
  output logic [31:0]         base_out_o,
  output logic [TS_WIDTH-1:0] ts_pel_o,
  output logic [TS_WIDTH-1:0] ts_size_o,
  output logic [TS_WIDTH-1:0] ts_out_o,
  output logic                busy_o,
  output logic                evt_done_o,
  output logic                err_cfg_o,
  output logic                err_to_o,
  output logic [15:0]         job_cnt_o
);

  // Counter is wide enough to hold TIMEOUT itself; it never gets past
  // TIMEOUT-1 because the FSM leaves RUN first.
  localparam int               CNT_W       = $clog2(TIMEOUT + 1);
  // The stall that would bring the counter to TIMEOUT-1 is the one that fires.
  localparam logic [CNT_W-1:0] STALL_LIMIT = CNT_W'(TIMEOUT - 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_LAUNCH = 3'd2,
    S_RUN    = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_e;

  state_e              state_q, state_d;

  logic [2:0]          done_vec;
  logic [2:0]          sticky_q, sticky_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [15:0]         job_cnt_q, job_cnt_d;
  logic [31:0]         base_pel_q, base_pel_d;
  logic [31:0]         base_size_q, base_size_d;
  logic [31:0]         base_out_q, base_out_d;
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic [TS_WIDTH-1:0] ts_size_q, ts_size_d;
  logic                req_q, req_d;
  logic                evt_q, evt_d;
  logic                err_to_q, err_to_d;

  logic                all_rdy;
  logic                progress;
  logic                all_done;
  logic                stall_hit;
  logic                accept;

  assign done_vec  = {done_pel_i, done_size_i, done_out_i};
  assign all_rdy   = rdy_pel_i & rdy_size_i & rdy_out_i;
  assign progress  = beat_i | (|done_vec);
  // Pulses arriving this cycle count towards completion.
  assign all_done  = &(sticky_q | done_vec);
  assign stall_hit = !progress && (cnt_q == STALL_LIMIT);
  // A soft clear in the same cycle wins over a start request.
  assign accept    = (state_q == S_IDLE) && start_i && (n_pel_i != '0) && !clear_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; completion is tested before timeout so it wins a tie
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_ARM;
      S_ARM:    if (all_rdy) state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_RUN;
      S_RUN: begin
        if (all_done)       state_d = S_DONE;
        else if (stall_hit) state_d = S_ERR;
      end
      S_DONE:   state_d = S_IDLE;
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_IDLE;
    endcase
    if (clear_i) state_d = S_IDLE;
  end

  // Registered outputs follow the state being entered
  always_comb begin
    req_d    = (state_d == S_LAUNCH);
    evt_d    = (state_d == S_DONE);
    err_to_d = (state_d == S_ERR);
  end

  // Descriptor latch, done tracking, stall counter and job counter next-state
  always_comb begin
    sticky_d    = sticky_q;
    cnt_d       = cnt_q;
    job_cnt_d   = job_cnt_q;
    base_pel_d  = base_pel_q;
    base_size_d = base_size_q;
    base_out_d  = base_out_q;
    ts_d        = ts_q;
    ts_size_d   = ts_size_q;

    if (accept) begin
      base_pel_d  = pel_addr_i;
      base_size_d = size_addr_i;
      base_out_d  = out_addr_i;
      ts_d        = n_pel_i;
      ts_size_d   = TS_WIDTH'(1);
    end

    case (state_q)
      S_LAUNCH: begin
        sticky_d = '0;
        cnt_d    = '0;
      end
      S_RUN: begin
        sticky_d = sticky_q | done_vec;
        cnt_d    = progress ? '0 : cnt_q + CNT_W'(1);
      end
      default: ;
    endcase

    // Counted on entry to DONE so the count moves together with evt_done_o.
    if (state_d == S_DONE) job_cnt_d = job_cnt_q + 16'd1;

    if (clear_i) begin
      sticky_d = '0;
      cnt_d    = '0;
    end
  end

  // Datapath and output registers; reset clears everything, soft clear goes through state_d
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sticky_q    <= '0;
      cnt_q       <= '0;
      job_cnt_q   <= '0;
      base_pel_q  <= '0;
      base_size_q <= '0;
      base_out_q  <= '0;
      ts_q        <= '0;
      ts_size_q   <= '0;
      req_q       <= 1'b0;
      evt_q       <= 1'b0;
      err_to_q    <= 1'b0;
    end else begin
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
      job_cnt_q   <= job_cnt_d;
      base_pel_q  <= base_pel_d;
      base_size_q <= base_size_d;
      base_out_q  <= base_out_d;
      ts_q        <= ts_d;
      ts_size_q   <= ts_size_d;
      req_q       <= req_d;
      evt_q       <= evt_d;
      err_to_q    <= err_to_d;
    end
  end

  assign req_start_pel_o  = req_q;
  assign req_start_size_o = req_q;
  assign req_start_out_o  = req_q;
  assign base_pel_o       = base_pel_q;
  assign base_size_o      = base_size_q;
  assign base_out_o       = base_out_q;
  assign ts_pel_o         = ts_q;
  assign ts_out_o         = ts_q;
  assign ts_size_o        = ts_size_q;
  assign evt_done_o       = evt_q;
  assign err_to_o         = err_to_q;
  assign job_cnt_o        = job_cnt_q;
  assign busy_o           = (state_q == S_ARM) || (state_q == S_LAUNCH) ||
                            (state_q == S_RUN) || (state_q == S_ERR);
  assign err_cfg_o        = (state_q == S_IDLE) && start_i && (n_pel_i == '0) &&
                            !clear_i && !rst_i;

endmodule

// File: tb/tb_roberts_mdc_stream_sequencer.sv
// Bench for roberts_mdc_stream_sequencer: scenario tasks with randomized done/beat
// traffic checked against an event-level model of job completion and timeout.
module tb_roberts_mdc_stream_sequencer;

  localparam int TSW = 16;
  localparam int TMO = 16;

  logic           clk = 1'b0;
  logic           rst_i, clear_i, start_i;
  logic [31:0]    pel_addr_i, size_addr_i, out_addr_i;
  logic [TSW-1:0] n_pel_i;
  logic           rdy_pel_i, rdy_size_i, rdy_out_i;
  logic           done_pel_i, done_size_i, done_out_i, beat_i;
  logic           req_start_pel_o, req_start_size_o, req_start_out_o;
  logic [31:0]    base_pel_o, base_size_o, base_out_o;
  logic [TSW-1:0] ts_pel_o, ts_size_o, ts_out_o;
  logic           busy_o, evt_done_o, err_cfg_o, err_to_o;
  logic [15:0]    job_cnt_o;

  roberts_mdc_stream_sequencer #(.TS_WIDTH(TSW), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
    .pel_addr_i(pel_addr_i), .size_addr_i(size_addr_i), .out_addr_i(out_addr_i),
    .n_pel_i(n_pel_i), .rdy_pel_i(rdy_pel_i), .rdy_size_i(rdy_size_i), .rdy_out_i(rdy_out_i),
    .done_pel_i(done_pel_i), .done_size_i(done_size_i), .done_out_i(done_out_i), .beat_i(beat_i),
    .req_start_pel_o(req_start_pel_o), .req_start_size_o(req_start_size_o),
    .req_start_out_o(req_start_out_o), .base_pel_o(base_pel_o), .base_size_o(base_size_o),
    .base_out_o(base_out_o), .ts_pel_o(ts_pel_o), .ts_size_o(ts_size_o), .ts_out_o(ts_out_o),
    .busy_o(busy_o), .evt_done_o(evt_done_o), .err_cfg_o(err_cfg_o), .err_to_o(err_to_o),
    .job_cnt_o(job_cnt_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Expected descriptor and job count
  int             m_job_cnt = 0;
  logic [31:0]    m_bp = '0, m_bs = '0, m_bo = '0;
  logic [TSW-1:0] m_n = '0, m_tsz = '0;

  // Per-RUN-cycle stimulus (index k = k-th cycle after LAUNCH)
  bit dp[128], ds[128], dq[128], bt[128];

  logic [32*3+3*TSW-1:0] obs_desc;
  logic [2:0]            obs_req;
  logic [166:0]          all_out;
  assign obs_desc = {base_pel_o, base_size_o, base_out_o, ts_pel_o, ts_size_o, ts_out_o};
  assign obs_req  = {req_start_pel_o, req_start_size_o, req_start_out_o};
  assign all_out  = {obs_req, busy_o, evt_done_o, err_cfg_o, err_to_o, job_cnt_o, obs_desc};

  function automatic logic [32*3+3*TSW-1:0] exp_desc();
    return {m_bp, m_bs, m_bo, m_n, m_tsz, m_n};
  endfunction

  // A job completes the cycle after all three streams have reported done;
  // it times out the cycle after TIMEOUT-1 consecutive cycles without progress.
  function automatic void model_run(input int n, output int evt_k, output int err_k);
    bit sp, ss, so;
    int stall;
    sp = 0; ss = 0; so = 0; stall = 0;
    evt_k = -1; err_k = -1;
    for (int k = 1; k <= n; k++) begin
      sp = sp | dp[k]; ss = ss | ds[k]; so = so | dq[k];
      if (sp && ss && so) begin evt_k = k + 1; return; end
      if (dp[k] || ds[k] || dq[k] || bt[k]) stall = 0; else stall = stall + 1;
      if (stall == TMO - 1) begin err_k = k + 1; return; end
    end
  endfunction

  task automatic fill_clear();
    for (int i = 0; i < 128; i++) begin dp[i] = 0; ds[i] = 0; dq[i] = 0; bt[i] = 0; end
  endtask

  task automatic fill_random(input int last, input int dens, input bit guard);
    fill_clear();
    dp[$urandom_range(1, last)] = 1;
    ds[$urandom_range(1, last)] = 1;
    dq[$urandom_range(1, last)] = 1;
    for (int k = 1; k <= last; k++)
      bt[k] = (int'($urandom_range(0, 3)) < dens) || (guard && (k % 8 == 0));
  endtask

  task automatic model_accept(input logic [TSW-1:0] n, input logic [31:0] pa, sa, oa);
    m_n = n; m_bp = pa; m_bs = sa; m_bo = oa; m_tsz = TSW'(1);
  endtask

  // Drives one start request; returns at the falling edge of the following cycle.
  task automatic start_job(input logic [TSW-1:0] n, input logic [31:0] pa, sa, oa);
    @(negedge clk);
    n_pel_i = n; pel_addr_i = pa; size_addr_i = sa; out_addr_i = oa; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Plays the RUN stimulus, observing outputs at each falling edge.
  task automatic play_run(input int n, output int evt_k, output int err_k, output int evt_cnt,
                          output int req_cnt, output logic busy_after);
    evt_k = -1; err_k = -1; evt_cnt = 0; req_cnt = 0; busy_after = 1'b1;
    for (int k = 1; k <= n + 2; k++) begin
      @(negedge clk);
      if (evt_done_o === 1'b1) begin evt_cnt++; if (evt_k < 0) evt_k = k; end
      if (evt_k >= 0 && k == evt_k + 1) busy_after = busy_o;
      if (err_to_o === 1'b1 && err_k < 0) err_k = k;
      if (obs_req !== 3'b000) req_cnt++;
      if (k <= n) begin
        done_pel_i = dp[k]; done_size_i = ds[k]; done_out_i = dq[k]; beat_i = bt[k];
      end else begin
        done_pel_i = 0; done_size_i = 0; done_out_i = 0; beat_i = 0;
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1; clear_i = 0; start_i = 0; n_pel_i = '0;
    pel_addr_i = '0; size_addr_i = '0; out_addr_i = '0;
    rdy_pel_i = 0; rdy_size_i = 0; rdy_out_i = 0;
    done_pel_i = 0; done_size_i = 0; done_out_i = 0; beat_i = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", all_out); end
    rst_i = 0;
    @(negedge clk);
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL reset_idle: got %h expected 0", all_out); end
  endtask

  task automatic test_basic();
    int ek, rk, ec, rc, mek, mrk;
    logic ba;
    logic [31:0] pa, sa, oa;
    pa = $urandom(); sa = $urandom(); oa = $urandom();
    rdy_pel_i = 1; rdy_size_i = 1; rdy_out_i = 1;
    start_job(TSW'(64), pa, sa, oa);
    model_accept(TSW'(64), pa, sa, oa);
    checks++;
    if (busy_o !== 1'b1 || obs_req !== 3'b000) begin
      errors++; $display("FAIL basic_arm: busy=%b req=%b expected busy=1 req=000", busy_o, obs_req);
    end
    checks++;
    if (obs_desc !== exp_desc()) begin
      errors++; $display("FAIL basic_desc: got %h expected %h", obs_desc, exp_desc());
    end
    @(negedge clk);
    checks++;
    if (obs_req !== 3'b111) begin errors++; $display("FAIL basic_launch: req=%b expected 111", obs_req); end
    fill_clear();
    ds[3] = 1; dp[70] = 1; dq[75] = 1;
    for (int k = 1; k <= 80; k++) bt[k] = ($urandom_range(0, 3) != 0) || (k % 8 == 0);
    model_run(80, mek, mrk);
    play_run(80, ek, rk, ec, rc, ba);
    checks++;
    if (ek !== mek || rk !== mrk) begin
      errors++; $display("FAIL basic_done_time: evt=%0d err=%0d expected evt=%0d err=%0d", ek, rk, mek, mrk);
    end
    checks++;
    if (ec !== 1 || rc !== 0 || ba !== 1'b0) begin
      errors++; $display("FAIL basic_pulses: evt_cnt=%0d req_cnt=%0d busy_after=%b expected 1 0 0", ec, rc, ba);
    end
    m_job_cnt = (m_job_cnt + 1) & 16'hFFFF;
    checks++;
    if (job_cnt_o !== 16'(m_job_cnt) || obs_desc !== exp_desc()) begin
      errors++; $display("FAIL basic_jobcnt: cnt=%0d desc=%h expected %0d %h", job_cnt_o, obs_desc, m_job_cnt, exp_desc());
    end
  endtask

  task automatic test_arm_wait();
    int ek, rk, ec, rc, mek, mrk;
    logic ba;
    logic [31:0] pa, sa, oa;
    logic [TSW-1:0] n;
    pa = $urandom(); sa = $urandom(); oa = $urandom(); n = TSW'($urandom_range(1, 500));
    rdy_pel_i = 1; rdy_size_i = 1; rdy_out_i = 0;
    start_job(n, pa, sa, oa);
    model_accept(n, pa, sa, oa);
    for (int i = 0; i < 10; i++) begin
      done_pel_i = 1'($urandom_range(0, 1)); done_size_i = 1'($urandom_range(0, 1));
      done_out_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (obs_req !== 3'b000 || busy_o !== 1'b1) begin
        errors++; $display("FAIL arm_hold: cycle=%0d req=%b busy=%b expected 000 1", i, obs_req, busy_o);
      end
    end
    done_pel_i = 0; done_size_i = 0; done_out_i = 0;
    rdy_out_i = 1;
    @(negedge clk);
    checks++;
    if (obs_req !== 3'b111) begin errors++; $display("FAIL arm_launch: req=%b expected 111", obs_req); end
    fill_random(30, 3, 1'b1);
    model_run(34, mek, mrk);
    play_run(34, ek, rk, ec, rc, ba);
    checks++;
    if (ek !== mek || rk !== mrk || ec !== 1) begin
      errors++; $display("FAIL arm_job: evt=%0d err=%0d cnt=%0d expected evt=%0d err=%0d cnt=1", ek, rk, ec, mek, mrk);
    end
    m_job_cnt = (m_job_cnt + 1) & 16'hFFFF;
    checks++;
    if (job_cnt_o !== 16'(m_job_cnt)) begin
      errors++; $display("FAIL arm_jobcnt: got %0d expected %0d", job_cnt_o, m_job_cnt);
    end
  endtask

  task automatic test_cfg_err();
    @(negedge clk);
    start_i = 1; n_pel_i = '0; pel_addr_i = $urandom(); size_addr_i = $urandom(); out_addr_i = $urandom();
    #1;
    checks++;
    if (err_cfg_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++; $display("FAIL cfg_pulse: err_cfg=%b busy=%b expected 1 0", err_cfg_o, busy_o);
    end
    @(negedge clk);
    start_i = 0;
    #1;
    checks++;
    if (err_cfg_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL cfg_after: err_cfg=%b busy=%b expected 0 0", err_cfg_o, busy_o);
    end
    checks++;
    if (obs_desc !== exp_desc()) begin
      errors++; $display("FAIL cfg_desc: got %h expected %h", obs_desc, exp_desc());
    end
  endtask

  task automatic test_timeout();
    int ek, rk, ec, rc, mek, mrk;
    logic ba;
    logic [31:0] pa, sa, oa;
    pa = $urandom(); sa = $urandom(); oa = $urandom();
    rdy_pel_i = 1; rdy_size_i = 1; rdy_out_i = 1;
    start_job(TSW'(5), pa, sa, oa);
    model_accept(TSW'(5), pa, sa, oa);
    @(negedge clk);
    fill_clear();
    model_run(20, mek, mrk);
    play_run(20, ek, rk, ec, rc, ba);
    checks++;
    if (rk !== mrk || rk !== TMO || ek !== -1) begin
      errors++; $display("FAIL timeout_time: err=%0d evt=%0d expected err=%0d evt=-1", rk, ek, mrk);
    end
    start_i = 1; n_pel_i = TSW'(7); pel_addr_i = ~pa; size_addr_i = ~sa; out_addr_i = ~oa;
    #1;
    checks++;
    if (err_cfg_o !== 1'b0) begin errors++; $display("FAIL timeout_cfg: err_cfg=%b expected 0", err_cfg_o); end
    repeat (3) @(negedge clk);
    start_i = 0;
    checks++;
    if (err_to_o !== 1'b1 || busy_o !== 1'b1 || obs_desc !== exp_desc()) begin
      errors++; $display("FAIL timeout_hold: err_to=%b busy=%b desc=%h expected 1 1 %h", err_to_o, busy_o, obs_desc, exp_desc());
    end
    clear_i = 1;
    @(negedge clk);
    clear_i = 0;
    checks++;
    if (err_to_o !== 1'b0 || busy_o !== 1'b0 || job_cnt_o !== 16'(m_job_cnt) || obs_desc !== exp_desc()) begin
      errors++; $display("FAIL timeout_clear: err_to=%b busy=%b cnt=%0d expected 0 0 %0d", err_to_o, busy_o, job_cnt_o, m_job_cnt);
    end
  endtask

  task automatic test_done_at_timeout();
    int ek, rk, ec, rc, mek, mrk;
    logic ba;
    rdy_pel_i = 1; rdy_size_i = 1; rdy_out_i = 1;
    start_job(TSW'(9), 32'h1000, 32'h2000, 32'h3000);
    model_accept(TSW'(9), 32'h1000, 32'h2000, 32'h3000);
    @(negedge clk);
    fill_clear();
    dp[TMO-1] = 1; ds[TMO-1] = 1; dq[TMO-1] = 1;
    model_run(20, mek, mrk);
    play_run(20, ek, rk, ec, rc, ba);
    checks++;
    if (ek !== mek || ek !== TMO || rk !== -1) begin
      errors++; $display("FAIL tie_done: evt=%0d err=%0d expected evt=%0d err=-1", ek, rk, mek);
    end
    m_job_cnt = (m_job_cnt + 1) & 16'hFFFF;
    checks++;
    if (err_to_o !== 1'b0 || job_cnt_o !== 16'(m_job_cnt)) begin
      errors++; $display("FAIL tie_state: err_to=%b cnt=%0d expected 0 %0d", err_to_o, job_cnt_o, m_job_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pa, sa, oa, pb, sb, ob;
    logic [TSW-1:0] na, nb;
    pa = $urandom(); sa = $urandom(); oa = $urandom(); na = TSW'($urandom_range(1, 1000));
    pb = $urandom(); sb = $urandom(); ob = $urandom(); nb = TSW'($urandom_range(1, 1000));
    rdy_pel_i = 1; rdy_size_i = 1; rdy_out_i = 1;
    @(negedge clk);
    start_i = 1; n_pel_i = na; pel_addr_i = pa; size_addr_i = sa; out_addr_i = oa;
    model_accept(na, pa, sa, oa);
    @(negedge clk);
    n_pel_i = nb; pel_addr_i = pb; size_addr_i = sb; out_addr_i = ob;
    @(negedge clk);
    checks++;
    if (obs_req !== 3'b111 || obs_desc !== exp_desc()) begin
      errors++; $display("FAIL b2b_launch1: req=%b desc=%h expected 111 %h", obs_req, obs_desc, exp_desc());
    end
    @(negedge clk);
    done_pel_i = 1; done_size_i = 1; done_out_i = 1;
    @(negedge clk);
    done_pel_i = 0; done_size_i = 0; done_out_i = 0;
    checks++;
    if (evt_done_o !== 1'b1 || obs_desc !== exp_desc()) begin
      errors++; $display("FAIL b2b_done1: evt=%b desc=%h expected 1 %h", evt_done_o, obs_desc, exp_desc());
    end
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || evt_done_o !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: busy=%b evt=%b expected 0 0", busy_o, evt_done_o);
    end
    model_accept(nb, pb, sb, ob);
    @(negedge clk);
    start_i = 0;
    checks++;
    if (busy_o !== 1'b1 || obs_desc !== exp_desc()) begin
      errors++; $display("FAIL b2b_arm2: busy=%b desc=%h expected 1 %h", busy_o, obs_desc, exp_desc());
    end
    @(negedge clk);
    checks++;
    if (obs_req !== 3'b111) begin errors++; $display("FAIL b2b_launch2: req=%b expected 111", obs_req); end
    @(negedge clk);
    done_pel_i = 1; done_size_i = 1; done_out_i = 1;
    @(negedge clk);
    done_pel_i = 0; done_size_i = 0; done_out_i = 0;
    m_job_cnt = (m_job_cnt + 2) & 16'hFFFF;
    checks++;
    if (evt_done_o !== 1'b1 || job_cnt_o !== 16'(m_job_cnt)) begin
      errors++; $display("FAIL b2b_done2: evt=%b cnt=%0d expected 1 %0d", evt_done_o, job_cnt_o, m_job_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int ek, rk, ec, rc, mek, mrk, d, sel, dens;
    logic ba;
    logic [31:0] pa, sa, oa;
    logic [TSW-1:0] n;
    for (int j = 0; j < 8; j++) begin
      pa = $urandom(); sa = $urandom(); oa = $urandom(); n = TSW'($urandom_range(1, 65535));
      d = $urandom_range(0, 4); sel = $urandom_range(0, 2); dens = $urandom_range(0, 3);
      rdy_pel_i = !(d > 0 && sel == 0); rdy_size_i = !(d > 0 && sel == 1); rdy_out_i = !(d > 0 && sel == 2);
      start_job(n, pa, sa, oa);
      model_accept(n, pa, sa, oa);
      for (int i = 0; i < d; i++) begin
        @(negedge clk);
        checks++;
        if (obs_req !== 3'b000) begin errors++; $display("FAIL rnd_arm: job=%0d req=%b expected 000", j, obs_req); end
      end
      rdy_pel_i = 1; rdy_size_i = 1; rdy_out_i = 1;
      @(negedge clk);
      checks++;
      if (obs_req !== 3'b111) begin errors++; $display("FAIL rnd_launch: job=%0d req=%b expected 111", j, obs_req); end
      fill_random(30, dens, 1'b0);
      model_run(34, mek, mrk);
      play_run(34, ek, rk, ec, rc, ba);
      checks++;
      if (ek !== mek || rk !== mrk) begin
        errors++; $display("FAIL rnd_outcome: job=%0d evt=%0d err=%0d expected evt=%0d err=%0d", j, ek, rk, mek, mrk);
      end
      if (mek > 0) m_job_cnt = (m_job_cnt + 1) & 16'hFFFF;
      checks++;
      if (job_cnt_o !== 16'(m_job_cnt) || obs_desc !== exp_desc()) begin
        errors++; $display("FAIL rnd_state: job=%0d cnt=%0d expected %0d", j, job_cnt_o, m_job_cnt);
      end
      if (mrk > 0) begin
        clear_i = 1;
        @(negedge clk);
        clear_i = 0;
      end
    end
  endtask

  task automatic test_clear_wrap();
    int ek, rk, ec, rc, mek, mrk;
    logic ba;
    logic [31:0] pa, sa, oa;
    @(negedge clk);
    force dut.job_cnt_q = 16'hFFFF;
    repeat (2) @(negedge clk);
    release dut.job_cnt_q;
    m_job_cnt = 16'hFFFF;
    @(negedge clk);
    checks++;
    if (job_cnt_o !== 16'hFFFF) begin errors++; $display("FAIL wrap_preset: got %h expected ffff", job_cnt_o); end
    pa = $urandom(); sa = $urandom(); oa = $urandom();
    rdy_pel_i = 1; rdy_size_i = 1; rdy_out_i = 1;
    start_job(TSW'(33), pa, sa, oa);
    model_accept(TSW'(33), pa, sa, oa);
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      beat_i = 1; done_size_i = (k == 2); done_pel_i = (k == 3);
    end
    @(negedge clk);
    beat_i = 0; done_size_i = 0; done_pel_i = 0;
    clear_i = 1;
    @(negedge clk);
    clear_i = 0;
    checks++;
    if (busy_o !== 1'b0 || err_to_o !== 1'b0 || job_cnt_o !== 16'hFFFF || obs_desc !== exp_desc()) begin
      errors++; $display("FAIL wrap_clear: busy=%b err_to=%b cnt=%h desc=%h expected 0 0 ffff %h", busy_o, err_to_o, job_cnt_o, obs_desc, exp_desc());
    end
    start_job(TSW'(12), pa, sa, oa);
    @(negedge clk);
    checks++;
    if (obs_req !== 3'b111) begin errors++; $display("FAIL wrap_launch: req=%b expected 111", obs_req); end
    fill_random(20, 3, 1'b1);
    model_accept(TSW'(12), pa, sa, oa);
    model_run(24, mek, mrk);
    play_run(24, ek, rk, ec, rc, ba);
    m_job_cnt = (m_job_cnt + 1) & 16'hFFFF;
    checks++;
    if (ek !== mek || job_cnt_o !== 16'(m_job_cnt)) begin
      errors++; $display("FAIL wrap_count: evt=%0d cnt=%h expected evt=%0d cnt=%h", ek, job_cnt_o, mek, 16'(m_job_cnt));
    end
  endtask

  task automatic test_rst_arm();
    rdy_pel_i = 1; rdy_size_i = 1; rdy_out_i = 0;
    start_job(TSW'(21), $urandom(), $urandom(), $urandom());
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL rst_arm_busy: got %b expected 1", busy_o); end
    rst_i = 1;
    @(negedge clk);
    rst_i = 0;
    m_job_cnt = 0; m_bp = '0; m_bs = '0; m_bo = '0; m_n = '0; m_tsz = '0;
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL rst_arm_outputs: got %h expected 0", all_out); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_arm_wait();
    test_cfg_err();
    test_timeout();
    test_done_at_timeout();
    test_back_to_back();
    test_random();
    test_clear_wrap();
    test_rst_arm();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
